// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the fetch and data requesters.
// Define MEM_ARB_FAIRNESS_EN to bound fetch starvation to STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_gnt,
  output logic                    i_rvalid,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    m_req,
  output logic                    m_we,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_be,
  input  logic                    m_ack,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE,
    OWN_I,
    OWN_D
  } state_t;

  state_t r_state;
  logic   w_win;
  logic   w_fetch_first;
  logic   w_gnt_i;
  logic   w_gnt_d;

  // Accept window: free port, or the owner completes this cycle.
  assign w_win = rst_n && ((r_state == IDLE) || m_ack);

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  logic [SW-1:0] r_starve;

  assign w_fetch_first = i_req && (r_starve == LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (!i_req || w_gnt_i) begin
      r_starve <= '0;
    end else if (w_gnt_d && (r_starve != LIM)) begin
      r_starve <= r_starve + SW'(1);
    end
  end
`else
  assign w_fetch_first = 1'b0;
`endif

  assign w_gnt_d  = w_win && d_req && !w_fetch_first;
  assign w_gnt_i  = w_win && i_req && !w_gnt_d;
  assign i_gnt    = w_gnt_i;
  assign d_gnt    = w_gnt_d;

  assign i_rvalid = (r_state == OWN_I) && m_ack;
  assign d_rvalid = (r_state == OWN_D) && m_ack;
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;
  assign busy     = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_be    <= '0;
    end else if (w_gnt_d) begin
      r_state <= OWN_D;
      m_req   <= 1'b1;
      m_we    <= d_we;
      m_addr  <= d_addr;
      m_wdata <= d_wdata;
      m_be    <= d_be;
    end else if (w_gnt_i) begin
      r_state <= OWN_I;
      m_req   <= 1'b1;
      m_we    <= 1'b0;
      m_addr  <= i_addr;
      m_be    <= '1;
    end else if (m_ack && (r_state != IDLE)) begin
      r_state <= IDLE;
      m_req   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus for mem_arbiter, checked every cycle
// against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int STARVE = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_gnt, i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [BW-1:0] d_be = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [BW-1:0] m_be;
  logic          m_ack = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic          busy;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .STARVE_LIMIT(STARVE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_be(d_be), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_be(m_be),
    .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: owner 0=none 1=fetch 2=data, plus the command it launched.
  int            mo = 0;
  int            ms = 0;
  logic          mwe = 1'b0;
  logic [AW-1:0] maddr = '0;
  logic [DW-1:0] mwd = '0;
  logic [BW-1:0] mbe = '0;

  function automatic int exp_win();
    bit win;
    bit ff;
    win = rst_n && (mo == 0 || m_ack);
    ff = 1'b0;
`ifdef MEM_ARB_FAIRNESS_EN
    ff = i_req && (ms >= STARVE);
`endif
    if (!win) return 0;
    if (d_req && !ff) return 2;
    if (i_req) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      mo = 0;
      ms = 0;
    end else begin
      w = exp_win();
      if (!i_req || w == 1) ms = 0;
      else if (w == 2) ms++;
      if (w == 2) begin
        mo = 2; mwe = d_we; maddr = d_addr;
        mwd = d_wdata; mbe = d_be;
      end else if (w == 1) begin
        mo = 1; mwe = 1'b0; maddr = i_addr; mbe = '1;
      end else if (m_ack) begin
        mo = 0;
      end
    end
  end

  always @(negedge clk) begin
    int w;
    w = exp_win();
    chk("i_gnt", i_gnt, w == 1);
    chk("d_gnt", d_gnt, w == 2);
    chk("i_rvalid", i_rvalid, mo == 1 && m_ack);
    chk("d_rvalid", d_rvalid, mo == 2 && m_ack);
    chk("busy", busy, mo != 0);
    chk("m_req", m_req, mo != 0);
    if (mo != 0) begin
      chk("m_addr", m_addr, maddr);
      chk("m_we", m_we, mwe);
      chk("m_be", m_be, mbe);
      if (mo == 2) chk("m_wdata", m_wdata, mwd);
    end
    if (i_rvalid) chk("i_rdata", i_rdata, m_rdata);
    if (d_rvalid) chk("d_rdata", d_rdata, m_rdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int nd, ni, cnt;
  logic [9:0] fpos;

  initial begin
    // reset state, requests pending under reset
    i_req = 1'b1;
    d_req = 1'b1;
    @(negedge clk);
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_m_req", m_req, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_be", m_be, 0);
    chk("rst_busy", busy, 0);
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
    rst_n = 1'b1;

    // idle fetch
    tick();
    i_req = 1'b1; i_addr = 32'h100;
    @(negedge clk);
    chk("t1_gnt", i_gnt, 1);
    tick();
    i_req = 1'b0;
    @(negedge clk);
    chk("t1_m_req", m_req, 1);
    chk("t1_m_addr", m_addr, 32'h100);
    chk("t1_m_we", m_we, 0);
    tick();
    m_ack = 1'b1; m_rdata = 32'h13;
    @(negedge clk);
    chk("t1_rvalid", i_rvalid, 1);
    chk("t1_rdata", i_rdata, 32'h13);
    tick();
    m_ack = 1'b0;
    @(negedge clk);
    chk("t1_busy", busy, 0);

    // collision: store wins, fetch granted in ack cycle
    tick();
    i_req = 1'b1; i_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200;
    d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    @(negedge clk);
    chk("t2_d_gnt", d_gnt, 1);
    chk("t2_i_gnt", i_gnt, 0);
    tick();
    d_req = 1'b0;
    @(negedge clk);
    chk("t2_m_we", m_we, 1);
    chk("t2_m_addr", m_addr, 32'h200);
    chk("t2_m_wdata", m_wdata, 32'hDEADBEEF);
    chk("t2_m_be", m_be, 4'b0011);
    chk("t2_i_wait", i_gnt, 0);
    tick();
    m_ack = 1'b1; m_rdata = 32'h0;
    @(negedge clk);
    chk("t2_d_rvalid", d_rvalid, 1);
    chk("t2_i_gnt_ack", i_gnt, 1);
    tick();
    i_req = 1'b0; m_ack = 1'b0;
    @(negedge clk);
    chk("t2_f_addr", m_addr, 32'h104);
    chk("t2_f_be", m_be, 4'hF);
    chk("t2_f_we", m_we, 0);
    tick();
    m_ack = 1'b1; m_rdata = 32'h55;
    @(negedge clk);
    chk("t2_i_rvalid", i_rvalid, 1);
    tick();
    m_ack = 1'b0;

    // back-to-back fetches
    tick();
    i_req = 1'b1; i_addr = 32'h300;
    @(negedge clk);
    chk("t3_gnt0", i_gnt, 1);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      m_ack = 1'b1;
      m_rdata = 32'h1000 + k;
      i_addr = 32'h304 + 4 * k;
      if (k == 2) i_req = 1'b0;
      @(negedge clk);
      if (i_rvalid) cnt++;
      chk("t3_rdata", i_rdata, 32'h1000 + k);
      chk("t3_m_addr", m_addr, 32'h300 + 4 * k);
      chk("t3_m_req", m_req, 1);
    end
    chk("t3_pulses", cnt, 3);
    tick();
    m_ack = 1'b0;
    @(negedge clk);
    chk("t3_idle", busy, 0);

    // fairness: both held, memory acks every cycle
    tick();
    i_req = 1'b1; i_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    d_wdata = 32'h0; d_be = 4'hF;
    m_ack = 1'b1; m_rdata = 32'hA5;
    nd = 0; ni = 0; fpos = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (d_gnt) nd++;
      if (i_gnt) begin ni++; fpos[k] = 1'b1; end
      tick();
    end
`ifdef MEM_ARB_FAIRNESS_EN
    chk("t4_d_cnt", nd, 8);
    chk("t4_i_cnt", ni, 2);
    chk("t4_pos", fpos, 10'b10_0001_0000);
`else
    chk("t4_d_cnt", nd, 10);
    chk("t4_i_cnt", ni, 0);
    chk("t4_pos", fpos, 0);
`endif
    i_req = 1'b0; d_req = 1'b0;
    tick();
    m_ack = 1'b0;
    @(negedge clk);
    chk("t4_idle", busy, 0);

    // reset mid-transaction
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_be = 4'hF;
    @(negedge clk);
    chk("t5_gnt", d_gnt, 1);
    tick();
    d_req = 1'b0;
    @(negedge clk);
    chk("t5_m_req", m_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_m_req", m_req, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_addr", m_addr, 0);
    m_ack = 1'b1;
    @(negedge clk);
    chk("t5_rst_rvalid", d_rvalid, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_stray_rvalid", d_rvalid, 0);
    chk("t5_stray_busy", busy, 0);
    tick();
    m_ack = 1'b0;

    // spurious ack in idle
    tick();
    m_ack = 1'b1; m_rdata = 32'hFFFF;
    @(negedge clk);
    chk("t6_i_rvalid", i_rvalid, 0);
    chk("t6_d_rvalid", d_rvalid, 0);
    chk("t6_busy", busy, 0);
    tick();
    m_ack = 1'b0;
    @(negedge clk);
    chk("t6_busy2", busy, 0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
